// File: rtl/ifetch_icache_unit_if.sv
// Fetch-unit bus bundle: memory-controller request/response, redirect input and
// the instruction stream towards the decoder / instruction queue.
interface ifetch_icache_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  iq_full;
  logic                  jump_en;
  logic [ADDR_WIDTH-1:0] jump_pc;
  logic                  mc_req_valid;
  logic [ADDR_WIDTH-1:0] mc_req_addr;
  logic                  mc_resp_valid;
  logic [31:0]           mc_resp_data;
  logic                  ins_valid;
  logic [31:0]           ins_data;
  logic [ADDR_WIDTH-1:0] ins_pc;
  logic [ADDR_WIDTH-1:0] ins_pred_pc;

  // Fetch unit side
  modport master (
    input  iq_full, jump_en, jump_pc, mc_resp_valid, mc_resp_data,
    output mc_req_valid, mc_req_addr, ins_valid, ins_data, ins_pc, ins_pred_pc
  );

  // Environment side (memory controller, commit stage, decoder)
  modport slave (
    output iq_full, jump_en, jump_pc, mc_resp_valid, mc_resp_data,
    input  mc_req_valid, mc_req_addr, ins_valid, ins_data, ins_pc, ins_pred_pc
  );
endinterface

// File: rtl/ifetch_icache_unit.sv
// Instruction fetch stage with a direct-mapped, one-word-per-line I-cache.
// Optional JAL target prediction is enabled by defining IFETCH_PREDICT_JAL_EN.
module ifetch_icache_unit #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    ICACHE_SIZE = 256,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rdy,
  ifetch_icache_unit_if.master bus
);

  localparam int IDX_W = $clog2(ICACHE_SIZE);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;

  typedef enum logic {
    IDLE      = 1'b0,
    MISS_WAIT = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] w_pc_next;
  logic                  r_req_valid;
  logic                  w_req_valid_next;
  logic [ADDR_WIDTH-1:0] r_req_addr;
  logic [ADDR_WIDTH-1:0] w_req_addr_next;
  logic                  r_ins_valid;
  logic                  w_ins_valid_next;
  logic [31:0]           r_ins_data;
  logic [31:0]           w_ins_data_next;
  logic [ADDR_WIDTH-1:0] r_ins_pc;
  logic [ADDR_WIDTH-1:0] w_ins_pc_next;
  logic [ADDR_WIDTH-1:0] r_ins_pred_pc;
  logic [ADDR_WIDTH-1:0] w_ins_pred_pc_next;
  logic                  w_fill_en;

  logic [31:0]           r_data  [ICACHE_SIZE];
  logic [TAG_W-1:0]      r_tag   [ICACHE_SIZE];
  logic [ICACHE_SIZE-1:0] r_valid;

  logic [IDX_W-1:0]      w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic [IDX_W-1:0]      w_fill_idx;
  logic [TAG_W-1:0]      w_fill_tag;
  logic                  w_hit;
  logic [31:0]           w_line;
  logic [ADDR_WIDTH-1:0] w_seq_pc;
  logic [ADDR_WIDTH-1:0] w_pred_pc;

  assign w_idx      = r_pc[IDX_W+1:2];
  assign w_tag      = r_pc[ADDR_WIDTH-1:IDX_W+2];
  assign w_fill_idx = r_req_addr[IDX_W+1:2];
  assign w_fill_tag = r_req_addr[ADDR_WIDTH-1:IDX_W+2];
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_line     = r_data[w_idx];
  assign w_seq_pc   = r_pc + ADDR_WIDTH'(4);

`ifdef IFETCH_PREDICT_JAL_EN
  logic                  w_is_jal;
  logic [ADDR_WIDTH-1:0] w_jal_imm;

  // J-type immediate: imm[20|10:1|11|19:12] sits in inst[31:12]
  assign w_is_jal  = (w_line[6:0] == 7'b1101111);
  assign w_jal_imm = {{(ADDR_WIDTH-21){w_line[31]}}, w_line[31], w_line[19:12],
                      w_line[20], w_line[30:21], 1'b0};
  assign w_pred_pc = w_is_jal ? (r_pc + w_jal_imm) : w_seq_pc;
`else
  assign w_pred_pc = w_seq_pc;
`endif

  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_req_valid_next   = r_req_valid;
    w_req_addr_next    = r_req_addr;
    w_ins_valid_next   = 1'b0;
    w_ins_data_next    = r_ins_data;
    w_ins_pc_next      = r_ins_pc;
    w_ins_pred_pc_next = r_ins_pred_pc;
    w_fill_en          = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (bus.jump_en) begin
          w_pc_next = bus.jump_pc;
        end else if (w_hit) begin
          if (!bus.iq_full) begin
            w_ins_valid_next   = 1'b1;
            w_ins_data_next    = w_line;
            w_ins_pc_next      = r_pc;
            w_ins_pred_pc_next = w_pred_pc;
            w_pc_next          = w_pred_pc;
          end
        end else begin
          w_req_valid_next = 1'b1;
          w_req_addr_next  = r_pc;
          w_state_next     = MISS_WAIT;
        end
      end

      MISS_WAIT: begin
        // The fill targets the latched request address, so a redirect taken
        // while waiting only moves the pc and never corrupts the line.
        if (bus.mc_resp_valid) begin
          w_fill_en        = 1'b1;
          w_req_valid_next = 1'b0;
          w_state_next     = IDLE;
        end
        if (bus.jump_en) begin
          w_pc_next = bus.jump_pc;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_req_valid   <= 1'b0;
      r_req_addr    <= '0;
      r_ins_valid   <= 1'b0;
      r_ins_data    <= '0;
      r_ins_pc      <= '0;
      r_ins_pred_pc <= '0;
      r_valid       <= '0;
    end else if (rdy) begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_req_valid   <= w_req_valid_next;
      r_req_addr    <= w_req_addr_next;
      r_ins_valid   <= w_ins_valid_next;
      r_ins_data    <= w_ins_data_next;
      r_ins_pc      <= w_ins_pc_next;
      r_ins_pred_pc <= w_ins_pred_pc_next;
      if (w_fill_en) begin
        r_valid[w_fill_idx] <= 1'b1;
      end
    end
  end

  // Line storage carries no reset; the valid vector alone qualifies it.
  always_ff @(posedge clk) begin
    if (!reset && rdy && w_fill_en) begin
      r_data[w_fill_idx] <= bus.mc_resp_data;
      r_tag[w_fill_idx]  <= w_fill_tag;
    end
  end

  assign bus.mc_req_valid = r_req_valid;
  assign bus.mc_req_addr  = r_req_addr;
  assign bus.ins_valid    = r_ins_valid;
  assign bus.ins_data     = r_ins_data;
  assign bus.ins_pc       = r_ins_pc;
  assign bus.ins_pred_pc  = r_ins_pred_pc;

endmodule

// File: tb/tb_ifetch_icache_unit.sv
// Directed bench for ifetch_icache_unit: cold start, hot loop, redirects,
// backpressure, pause, conflict misses, reset mid-miss and JAL prediction.
module tb_ifetch_icache_unit;

  logic clk = 1'b0;
  logic reset;
  logic rdy;
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef IFETCH_PREDICT_JAL_EN
  localparam logic [31:0] JAL_NEXT = 32'h30;
`else
  localparam logic [31:0] JAL_NEXT = 32'h14;
`endif
  localparam logic [31:0] JAL_WORD = 32'h0200006F;  // jal x0, +0x20

  always #5 clk = ~clk;

  ifetch_icache_unit_if #(.ADDR_WIDTH(32)) bus ();

  ifetch_icache_unit #(
    .ADDR_WIDTH (32),
    .ICACHE_SIZE(256),
    .RESET_PC   (32'h0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .rdy  (rdy),
    .bus  (bus)
  );

  // Memory image: address-tagged addi words, with a JAL planted at 0x10
  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == 32'h10) return JAL_WORD;
    return {a[11:0], 20'h00013};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic serve(input logic [31:0] d);
    bus.mc_resp_valid = 1'b1;
    bus.mc_resp_data  = d;
    tick();
    bus.mc_resp_valid = 1'b0;
    bus.mc_resp_data  = '0;
  endtask

  task automatic jump(input logic [31:0] t);
    bus.jump_en = 1'b1;
    bus.jump_pc = t;
    tick();
    bus.jump_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rdy   = 1'b1;
    bus.iq_full       = 1'b0;
    bus.jump_en       = 1'b0;
    bus.jump_pc       = '0;
    bus.mc_resp_valid = 1'b0;
    bus.mc_resp_data  = '0;
    tick();
    tick();
    n_cmp++;
    if ({bus.mc_req_valid, bus.mc_req_addr} !== 33'h0) begin
      n_bad++;
      $display("FAIL reset_req got %b/%h exp 0/00000000", bus.mc_req_valid, bus.mc_req_addr);
    end
    n_cmp++;
    if ({bus.ins_valid, bus.ins_data, bus.ins_pc, bus.ins_pred_pc} !== 97'h0) begin
      n_bad++;
      $display("FAIL reset_ins got v=%b d=%h pc=%h pp=%h exp all zero",
               bus.ins_valid, bus.ins_data, bus.ins_pc, bus.ins_pred_pc);
    end
    reset = 1'b0;
  endtask

  task automatic test_cold_start();
    tick();
    n_cmp++;
    if ({bus.mc_req_valid, bus.mc_req_addr} !== {1'b1, 32'h0}) begin
      n_bad++;
      $display("FAIL cold_req got %b/%h exp 1/00000000", bus.mc_req_valid, bus.mc_req_addr);
    end
    tick();
    tick();
    tick();
    n_cmp++;
    if ({bus.mc_req_valid, bus.mc_req_addr, bus.ins_valid} !== {1'b1, 32'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL cold_hold got %b/%h iv=%b exp 1/00000000 iv=0",
               bus.mc_req_valid, bus.mc_req_addr, bus.ins_valid);
    end
    serve(32'h00000013);
    n_cmp++;
    if ({bus.mc_req_valid, bus.ins_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL cold_fill got req=%b iv=%b exp 0 0", bus.mc_req_valid, bus.ins_valid);
    end
    tick();
    n_cmp++;
    if ({bus.ins_valid, bus.ins_pc, bus.ins_data, bus.ins_pred_pc} !==
        {1'b1, 32'h0, 32'h00000013, 32'h4}) begin
      n_bad++;
      $display("FAIL cold_ins got v=%b pc=%h d=%h pp=%h exp 1 00000000 00000013 00000004",
               bus.ins_valid, bus.ins_pc, bus.ins_data, bus.ins_pred_pc);
    end
    tick();
    n_cmp++;
    if ({bus.mc_req_valid, bus.mc_req_addr, bus.ins_valid} !== {1'b1, 32'h4, 1'b0}) begin
      n_bad++;
      $display("FAIL cold_next_req got %b/%h iv=%b exp 1/00000004 iv=0",
               bus.mc_req_valid, bus.mc_req_addr, bus.ins_valid);
    end
  endtask

  task automatic test_hot_loop();
    logic [31:0] a;
    for (int k = 1; k < 4; k++) begin
      a = 32'(4 * k);
      n_cmp++;
      if ({bus.mc_req_valid, bus.mc_req_addr} !== {1'b1, a}) begin
        n_bad++;
        $display("FAIL preload_req got %b/%h exp 1/%h", bus.mc_req_valid, bus.mc_req_addr, a);
      end
      serve(word_at(a));
      tick();
      n_cmp++;
      if ({bus.ins_valid, bus.ins_pc, bus.ins_data} !== {1'b1, a, word_at(a)}) begin
        n_bad++;
        $display("FAIL preload_ins got %b/%h/%h exp 1/%h/%h",
                 bus.ins_valid, bus.ins_pc, bus.ins_data, a, word_at(a));
      end
      tick();
    end
    // miss on 0x10 is outstanding; redirect to 0x0 while it waits
    jump(32'h0);
    n_cmp++;
    if ({bus.mc_req_valid, bus.mc_req_addr, bus.ins_valid} !== {1'b1, 32'h10, 1'b0}) begin
      n_bad++;
      $display("FAIL miss_jump_hold got %b/%h iv=%b exp 1/00000010 iv=0",
               bus.mc_req_valid, bus.mc_req_addr, bus.ins_valid);
    end
    serve(word_at(32'h10));
    n_cmp++;
    if ({bus.ins_valid, bus.mc_req_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL redirected_fill got iv=%b req=%b exp 0 0", bus.ins_valid, bus.mc_req_valid);
    end
    for (int k = 0; k < 4; k++) begin
      a = 32'(4 * k);
      tick();
      n_cmp++;
      if ({bus.ins_valid, bus.ins_pc, bus.ins_data, bus.mc_req_valid} !==
          {1'b1, a, word_at(a), 1'b0}) begin
        n_bad++;
        $display("FAIL hot_loop got v=%b pc=%h d=%h req=%b exp 1/%h/%h/0",
                 bus.ins_valid, bus.ins_pc, bus.ins_data, bus.mc_req_valid, a, word_at(a));
      end
    end
  endtask

  task automatic test_jal_predict();
    tick();
    n_cmp++;
    if ({bus.ins_valid, bus.ins_pc, bus.ins_data, bus.ins_pred_pc} !==
        {1'b1, 32'h10, JAL_WORD, JAL_NEXT}) begin
      n_bad++;
      $display("FAIL jal_pred got v=%b pc=%h d=%h pp=%h exp 1/00000010/%h/%h",
               bus.ins_valid, bus.ins_pc, bus.ins_data, bus.ins_pred_pc, JAL_WORD, JAL_NEXT);
    end
    tick();
    n_cmp++;
    if ({bus.mc_req_valid, bus.mc_req_addr} !== {1'b1, JAL_NEXT}) begin
      n_bad++;
      $display("FAIL jal_next_req got %b/%h exp 1/%h", bus.mc_req_valid, bus.mc_req_addr, JAL_NEXT);
    end
    serve(word_at(JAL_NEXT));
    tick();
    n_cmp++;
    if ({bus.ins_valid, bus.ins_pc} !== {1'b1, JAL_NEXT}) begin
      n_bad++;
      $display("FAIL jal_next_ins got %b/%h exp 1/%h", bus.ins_valid, bus.ins_pc, JAL_NEXT);
    end
  endtask

  task automatic test_backpressure();
    jump(32'h0);
    n_cmp++;
    if ({bus.ins_valid, bus.mc_req_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL idle_jump got iv=%b req=%b exp 0 0", bus.ins_valid, bus.mc_req_valid);
    end
    tick();
    tick();
    n_cmp++;
    if ({bus.ins_valid, bus.ins_pc} !== {1'b1, 32'h4}) begin
      n_bad++;
      $display("FAIL bp_before got %b/%h exp 1/00000004", bus.ins_valid, bus.ins_pc);
    end
    bus.iq_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if ({bus.ins_valid, bus.mc_req_valid} !== 2'b00) begin
        n_bad++;
        $display("FAIL bp_stall got iv=%b req=%b exp 0 0", bus.ins_valid, bus.mc_req_valid);
      end
    end
    bus.iq_full = 1'b0;
    tick();
    n_cmp++;
    if ({bus.ins_valid, bus.ins_pc, bus.ins_data} !== {1'b1, 32'h8, word_at(32'h8)}) begin
      n_bad++;
      $display("FAIL bp_resume got %b/%h/%h exp 1/00000008", bus.ins_valid, bus.ins_pc, bus.ins_data);
    end
    tick();
    n_cmp++;
    if ({bus.ins_valid, bus.ins_pc} !== {1'b1, 32'hC}) begin
      n_bad++;
      $display("FAIL bp_resume2 got %b/%h exp 1/0000000c", bus.ins_valid, bus.ins_pc);
    end
  endtask

  task automatic test_pause();
    rdy = 1'b0;
    bus.jump_en = 1'b1;
    bus.jump_pc = 32'h40;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if ({bus.ins_valid, bus.ins_pc, bus.ins_data, bus.ins_pred_pc, bus.mc_req_valid} !==
          {1'b1, 32'hC, word_at(32'hC), 32'h10, 1'b0}) begin
        n_bad++;
        $display("FAIL pause_freeze got v=%b pc=%h d=%h pp=%h req=%b exp 1/0000000c/%h/00000010/0",
                 bus.ins_valid, bus.ins_pc, bus.ins_data, bus.ins_pred_pc, bus.mc_req_valid,
                 word_at(32'hC));
      end
    end
    rdy = 1'b1;
    bus.jump_en = 1'b0;
    tick();
    n_cmp++;
    if ({bus.ins_valid, bus.ins_pc, bus.ins_pred_pc} !== {1'b1, 32'h10, JAL_NEXT}) begin
      n_bad++;
      $display("FAIL pause_resume got %b/%h/%h exp 1/00000010/%h",
               bus.ins_valid, bus.ins_pc, bus.ins_pred_pc, JAL_NEXT);
    end
  endtask

  task automatic test_redirect_miss();
    jump(32'h40);
    tick();
    n_cmp++;
    if ({bus.mc_req_valid, bus.mc_req_addr} !== {1'b1, 32'h40}) begin
      n_bad++;
      $display("FAIL rd_req40 got %b/%h exp 1/00000040", bus.mc_req_valid, bus.mc_req_addr);
    end
    serve(word_at(32'h40));
    tick();
    tick();
    n_cmp++;
    if ({bus.mc_req_valid, bus.mc_req_addr} !== {1'b1, 32'h44}) begin
      n_bad++;
      $display("FAIL rd_req44 got %b/%h exp 1/00000044", bus.mc_req_valid, bus.mc_req_addr);
    end
    // response and redirect in the same cycle
    bus.jump_en = 1'b1;
    bus.jump_pc = 32'h100;
    serve(word_at(32'h44));
    bus.jump_en = 1'b0;
    n_cmp++;
    if ({bus.ins_valid, bus.mc_req_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL rd_same_cycle got iv=%b req=%b exp 0 0", bus.ins_valid, bus.mc_req_valid);
    end
    tick();
    n_cmp++;
    if ({bus.mc_req_valid, bus.mc_req_addr} !== {1'b1, 32'h100}) begin
      n_bad++;
      $display("FAIL rd_req100 got %b/%h exp 1/00000100", bus.mc_req_valid, bus.mc_req_addr);
    end
    jump(32'h40);
    tick();
    n_cmp++;
    if ({bus.mc_req_valid, bus.mc_req_addr, bus.ins_valid} !== {1'b1, 32'h100, 1'b0}) begin
      n_bad++;
      $display("FAIL rd_hold got %b/%h iv=%b exp 1/00000100 iv=0",
               bus.mc_req_valid, bus.mc_req_addr, bus.ins_valid);
    end
    serve(word_at(32'h100));
    n_cmp++;
    if (bus.ins_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_not_forwarded got iv=%b exp 0", bus.ins_valid);
    end
    tick();
    n_cmp++;
    if ({bus.ins_valid, bus.ins_pc, bus.ins_data} !== {1'b1, 32'h40, word_at(32'h40)}) begin
      n_bad++;
      $display("FAIL rd_ins40 got %b/%h/%h exp 1/00000040/%h",
               bus.ins_valid, bus.ins_pc, bus.ins_data, word_at(32'h40));
    end
    tick();
    n_cmp++;
    if ({bus.ins_valid, bus.ins_pc, bus.ins_data, bus.mc_req_valid} !==
        {1'b1, 32'h44, word_at(32'h44), 1'b0}) begin
      n_bad++;
      $display("FAIL rd_ins44 got %b/%h/%h req=%b exp 1/00000044/%h/0",
               bus.ins_valid, bus.ins_pc, bus.ins_data, bus.mc_req_valid, word_at(32'h44));
    end
    tick();
    serve(word_at(32'h48));
    jump(32'h100);
    tick();
    n_cmp++;
    if ({bus.ins_valid, bus.ins_pc, bus.ins_data, bus.mc_req_valid} !==
        {1'b1, 32'h100, word_at(32'h100), 1'b0}) begin
      n_bad++;
      $display("FAIL rd_line100_valid got %b/%h/%h req=%b exp 1/00000100/%h/0",
               bus.ins_valid, bus.ins_pc, bus.ins_data, bus.mc_req_valid, word_at(32'h100));
    end
  endtask

  task automatic test_conflict();
    jump(32'h400);
    tick();
    n_cmp++;
    if ({bus.mc_req_valid, bus.mc_req_addr} !== {1'b1, 32'h400}) begin
      n_bad++;
      $display("FAIL cf_miss400 got %b/%h exp 1/00000400", bus.mc_req_valid, bus.mc_req_addr);
    end
    serve(word_at(32'h400));
    tick();
    n_cmp++;
    if ({bus.ins_valid, bus.ins_pc, bus.ins_data} !== {1'b1, 32'h400, word_at(32'h400)}) begin
      n_bad++;
      $display("FAIL cf_ins400 got %b/%h/%h exp 1/00000400/%h",
               bus.ins_valid, bus.ins_pc, bus.ins_data, word_at(32'h400));
    end
    jump(32'h0);
    tick();
    n_cmp++;
    if ({bus.mc_req_valid, bus.mc_req_addr} !== {1'b1, 32'h0}) begin
      n_bad++;
      $display("FAIL cf_remiss0 got %b/%h exp 1/00000000", bus.mc_req_valid, bus.mc_req_addr);
    end
    serve(32'h00000013);
    tick();
    n_cmp++;
    if ({bus.ins_valid, bus.ins_pc, bus.ins_data} !== {1'b1, 32'h0, 32'h00000013}) begin
      n_bad++;
      $display("FAIL cf_ins0 got %b/%h/%h exp 1/00000000/00000013",
               bus.ins_valid, bus.ins_pc, bus.ins_data);
    end
  endtask

  task automatic test_reset_mid_miss();
    jump(32'h800);
    tick();
    n_cmp++;
    if ({bus.mc_req_valid, bus.mc_req_addr} !== {1'b1, 32'h800}) begin
      n_bad++;
      $display("FAIL rm_miss got %b/%h exp 1/00000800", bus.mc_req_valid, bus.mc_req_addr);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if ({bus.mc_req_valid, bus.mc_req_addr, bus.ins_valid} !== 34'h0) begin
      n_bad++;
      $display("FAIL rm_abandon got %b/%h iv=%b exp 0/00000000 iv=0",
               bus.mc_req_valid, bus.mc_req_addr, bus.ins_valid);
    end
    // stale response after reset must not fill line 0
    bus.mc_resp_valid = 1'b1;
    bus.mc_resp_data  = 32'hDEADBEEF;
    bus.jump_en       = 1'b1;
    bus.jump_pc       = 32'h0;
    tick();
    bus.mc_resp_valid = 1'b0;
    bus.mc_resp_data  = '0;
    bus.jump_en       = 1'b0;
    tick();
    n_cmp++;
    if ({bus.mc_req_valid, bus.mc_req_addr, bus.ins_valid} !== {1'b1, 32'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL rm_stale_ignored got %b/%h iv=%b d=%h exp 1/00000000 iv=0",
               bus.mc_req_valid, bus.mc_req_addr, bus.ins_valid, bus.ins_data);
    end
    serve(32'h00000013);
  endtask

  initial begin
    test_reset();
    test_cold_start();
    test_hot_loop();
    test_jal_predict();
    test_backpressure();
    test_pause();
    test_redirect_miss();
    test_conflict();
    test_reset_mid_miss();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifetch_icache_unit.md
Name: ifetch_icache_unit

Overview:
- Next-generation instruction fetch stage with a parametrised direct-mapped I-cache.
- Holds the PC and looks it up in the cache. On a miss, it requests a word from the memory controller, fills the line and retries.
- Hands one instruction per cycle to the decoder/instruction queue.
- Accepts redirects from the commit stage and obeys the global rdy pause.

Parameters:
- ADDR_WIDTH, 32, PC / memory address width in bits.
- ICACHE_SIZE, 256, number of one-word lines; must be a power of two. IDX_W = log2(ICACHE_SIZE).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- rdy  in  1  global ready; low = freeze all state
- iq_full  in  1  downstream cannot accept an instruction this cycle
- jump_en  in  1  redirect request from commit/ROB
- jump_pc  in  ADDR_WIDTH  redirect target
- mc_req_valid  out  1  fetch request to memory controller
- mc_req_addr  out  ADDR_WIDTH  word address of the request
- mc_resp_valid  in  1  one-cycle pulse: response data valid
- mc_resp_data  in  32  instruction word returned
- ins_valid  out  1  instruction valid to decoder
- ins_data  out  32  instruction word
- ins_pc  out  ADDR_WIDTH  PC of ins_data
- ins_pred_pc  out  ADDR_WIDTH  predicted next PC for ins_data

Behaviour:
- Address split:
  - Index = pc[IDX_W+1:2].
  - Tag = pc[ADDR_WIDTH-1:IDX_W+2].
  - pc[1:0] are always 0.
  - hit = valid[idx] && tag[idx] == pc tag (combinational).
- Reset:
  - pc = RESET_PC; all valid bits = 0; state = IDLE.
  - mc_req_valid = 0, mc_req_addr = 0.
  - ins_valid = 0, ins_data = 0, ins_pc = 0, ins_pred_pc = 0.
  - Reset mid-miss abandons the request. Any mc_resp_valid seen in the cycle after reset is ignored (no fill).
- rdy = 0: no register changes, except that reset still wins. Outputs hold their values.
- States: IDLE, MISS_WAIT.
- IDLE:
  - ins_valid defaults to 0 each cycle.
  - hit && !iq_full: next cycle ins_valid = 1, ins_data = line data, ins_pc = pc, ins_pred_pc = next_pc. pc <= next_pc. Hit-to-output latency is 1 cycle; back-to-back hits give 1 instruction/cycle.
  - hit && iq_full: pc holds, ins_valid = 0.
  - !hit: mc_req_valid <= 1, mc_req_addr <= pc, state -> MISS_WAIT.
  - Default next_pc = pc + 4, wrapping modulo 2^ADDR_WIDTH.
- MISS_WAIT:
  - mc_req_valid and mc_req_addr are held stable until mc_resp_valid.
  - On mc_resp_valid: write data, tag and valid at the index of mc_req_addr. Drop mc_req_valid in the next cycle. State -> IDLE.
  - The fill always uses the latched request address, so it is correct even after a redirect.
  - Fill-to-output: IDLE hits in the cycle after the fill, so ins_valid appears 2 cycles after the response.
- jump_en (highest priority after reset, any state):
  - pc <= jump_pc; ins_valid <= 0 in the next cycle.
  - In IDLE: no lookup is issued that cycle.
  - In MISS_WAIT: the request stays outstanding. Its response still fills the cache but is not forwarded. The state returns to IDLE afterwards and looks up the new pc.
  - jump_en in the same cycle as mc_resp_valid: the fill happens and pc takes jump_pc.
- Conflict misses overwrite the line unconditionally.
- The cache is never invalidated except by reset.

Optional Feature:
- Macro: IFETCH_PREDICT_JAL_EN.
- Defined: on a hit whose word has opcode[6:0] = 7'b1101111 (JAL), next_pc = pc + sign-extended J-immediate, both for the pc update and for ins_pred_pc. Other instructions use pc + 4.
- Undefined: next_pc is always pc + 4. No decode logic is present.

Test Plan:
- Cold start: reset, then hold mc_resp_valid low until the first request.
  - Required: mc_req_valid = 1 with mc_req_addr = 0x0 one cycle after reset release.
  - Response 0x00000013 at cycle 5: ins_valid = 1, ins_pc = 0x0, ins_data = 0x00000013 at cycle 7, followed by a request for 0x4.
- Hot loop: preload lines 0x0–0xC, jump_en to 0x0, and keep iq_full low.
  - Required: ins_pc = 0x0, 0x4, 0x8, 0xC on consecutive cycles with no mc_req_valid.
- Backpressure and pause:
  - Assert iq_full for 3 cycles mid-stream: ins_valid = 0, pc held, then resumes with no instruction skipped or duplicated.
  - Drop rdy for 4 cycles: all outputs frozen.
- Redirect during miss: a miss on 0x100 is pending; jump_en to 0x40 (cached).
  - Required: the response for 0x100 is not forwarded and the line for 0x100 becomes valid.
  - The next ins_valid carries ins_pc = 0x40.
- Conflict (ICACHE_SIZE = 256): fetch 0x0, then 0x400 (same index, different tag).
  - Required: 0x400 misses and fills; a refetch of 0x0 misses again.
- With IFETCH_PREDICT_JAL_EN: the word at 0x10 is JAL +0x20.
  - Required: ins_pred_pc = 0x30 and the next ins_pc = 0x30.
  - Without the macro: ins_pred_pc = 0x14.
